// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Constants and types shared by the systolic-array blocks (sa_top, sa_c_drain).
//   SA_WIDTH      : default element width in bits
//   SA_SIZE       : default array dimension (rows per tile, elements per row)
//   SA_IDX_W      : width of a row index within a tile
//   sa_c_entry_t  : one drain FIFO entry, a result row tagged with its index
//   sa_idx_w()    : index width for an arbitrary SIZE (never below 1 bit)
// ---------------------------------------------------------------------------
package sa_pkg;

    localparam int SA_WIDTH = 16;
    localparam int SA_SIZE  = 4;
    localparam int SA_IDX_W = $clog2(SA_SIZE);

    // Index sits in the MSBs, row in the LSBs; sa_c_drain packs its FIFO
    // words in the same order.
    typedef struct packed {
        logic [SA_IDX_W-1:0]                idx;
        logic [SA_SIZE-1:0][SA_WIDTH-1:0]   row;
    } sa_c_entry_t;

    function automatic int sa_idx_w(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// ---------------------------------------------------------------------------
// sa_row_fifo
// Generic single-clock synchronous FIFO with a combinational read port.
//   clk      : clock
//   rst_n    : synchronous active-low reset (pointers and count only)
//   push     : write wr_data (ignored when full unless pop is also high)
//   pop      : advance the read pointer (ignored when empty)
//   wr_data  : data to write
//   rd_data  : entry at the read pointer (undefined while empty)
//   count    : number of stored entries, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sa_row_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when a slot frees up in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Read is combinational so a row written at edge N is presented right
    // after that edge, without a prefetch stage.
    assign rd_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sa_c_drain.sv
// ---------------------------------------------------------------------------
// sa_c_drain
// Drain stage behind sa_top: buffers result rows, tags each with its row index
// within the C tile, and presents them on a valid/ready interface.
//   clk          : clock
//   i_rst_n      : synchronous active-low reset
//   i_c_vld      : result row valid from sa_top (no backpressure)
//   i_c_rows     : result row from sa_top
//   o_tile_room  : at least SIZE free FIFO entries (credit for the sequencer)
//   o_vld        : output row valid
//   i_rdy        : consumer accepts the output row
//   o_row        : output row (0 while o_vld is low)
//   o_row_idx    : index of o_row within its tile (0 while o_vld is low)
//   o_last       : o_row is the last row of its tile
//   o_ovf        : sticky, a row arrived while the FIFO was full and was lost
//   i_clr_ovf    : clears o_ovf (a drop in the same cycle wins)
//   o_tiles      : count of fully drained tiles, wraps at 2^16
// ---------------------------------------------------------------------------
module sa_c_drain
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int SIZE  = SA_SIZE,
    parameter int DEPTH = 8,
    localparam int IDX_W = sa_idx_w(SIZE)
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic                        i_c_vld,
    input  logic [SIZE-1:0][WIDTH-1:0]  i_c_rows,
    output logic                        o_tile_room,
    output logic                        o_vld,
    input  logic                        i_rdy,
    output logic [SIZE-1:0][WIDTH-1:0]  o_row,
    output logic [IDX_W-1:0]            o_row_idx,
    output logic                        o_last,
    output logic                        o_ovf,
    input  logic                        i_clr_ovf,
    output logic [15:0]                 o_tiles
);

    localparam int ROW_W = SIZE * WIDTH;
    localparam int ENT_W = ROW_W + IDX_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SIZE_C  = CNT_W'(SIZE);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(SIZE - 1);

    logic [IDX_W-1:0]               in_idx_reg;
    logic [IDX_W-1:0]               in_idx_next;
    logic                           ovf_reg;
    logic [15:0]                    tiles_reg;

    logic                           fifo_push;
    logic                           fifo_pop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CNT_W-1:0]               fifo_count;
    logic [ENT_W-1:0]               fifo_wr_data;
    logic [ENT_W-1:0]               fifo_rd_data;
    logic [SIZE-1:0][WIDTH-1:0]     rd_row;
    logic [IDX_W-1:0]               rd_idx;
    logic [CNT_W-1:0]               free_cnt;
    logic                           drop;

    assign fifo_pop     = !fifo_empty && i_rdy;
    // Rows arriving during reset are ignored entirely.
    assign fifo_push    = i_rst_n && i_c_vld && (!fifo_full || fifo_pop);
    assign drop         = i_rst_n && i_c_vld && fifo_full && !fifo_pop;
    assign fifo_wr_data = {in_idx_reg, i_c_rows};

    sa_row_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (i_rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_row = fifo_rd_data[ROW_W-1:0];
    assign rd_idx = fifo_rd_data[ENT_W-1:ROW_W];

    // Outputs are gated to zero while empty so stale memory never leaks out.
    assign o_vld     = !fifo_empty;
    assign o_row_idx = o_vld ? rd_idx : '0;
    assign o_last    = o_vld && (rd_idx == LAST_C);

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_row_gate
            assign o_row[gi] = o_vld ? rd_row[gi] : '0;
        end
    endgenerate

    assign free_cnt    = DEPTH_C - fifo_count;
    assign o_tile_room = (free_cnt >= SIZE_C);
    assign o_ovf       = ovf_reg;
    assign o_tiles     = tiles_reg;

    // The tile index advances on every incoming row, dropped or not, so a
    // drop never shifts later rows into the wrong tile position.
    assign in_idx_next = (in_idx_reg == LAST_C) ? '0 : in_idx_reg + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            in_idx_reg <= '0;
            ovf_reg    <= 1'b0;
            tiles_reg  <= '0;
        end else begin
            if (i_c_vld) begin
                in_idx_reg <= in_idx_next;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (i_clr_ovf) begin
                ovf_reg <= 1'b0;
            end
            if (fifo_pop && (rd_idx == LAST_C)) begin
                tiles_reg <= tiles_reg + 16'd1;
            end
        end
    end

endmodule

// File: doc/sa_c_drain.md
# sa_c_drain

Output drain stage for the systolic array: it sits directly downstream of `sa_top`. Each cycle that `sa_top` raises `o_c_vld`, this block captures the result row `o_c_rows` into a row FIFO and tags it with its row index within the current C tile. It then hands the rows to the consumer over a valid/ready handshake. `sa_top` has no backpressure, so the block also gives the upstream sequencer a tile-room credit and flags dropped rows with a sticky overflow bit.

## Interface
- `WIDTH`, 16, element width in bits.
- `SIZE`, 4, array dimension; rows per tile and elements per row. Must be ≥2.
- `DEPTH`, 8, FIFO depth in rows. Must be a power of two and ≥ `SIZE`.

- `clk` in 1: the single clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_c_vld` in 1: row valid; connects to `sa_top.o_c_vld`.
- `i_c_rows` in `SIZE*WIDTH` (packed `[SIZE-1:0][WIDTH-1:0]`): result row; connects to `sa_top.o_c_rows`.
- `o_tile_room` out 1: FIFO has at least `SIZE` free entries.
- `o_vld` out 1: output row valid.
- `i_rdy` in 1: consumer accepts a row.
- `o_row` out `SIZE*WIDTH`: output row.
- `o_row_idx` out `$clog2(SIZE)`: index of `o_row` within its tile.
- `o_last` out 1: `o_row` is row `SIZE-1` of its tile.
- `o_ovf` out 1: sticky flag; set when a row was dropped.
- `i_clr_ovf` in 1: clears `o_ovf`.
- `o_tiles` out 16: count of tiles fully drained; wraps modulo 2^16.

## Operation
- Each FIFO entry holds one row plus its index tag `in_idx`. The FIFO state is `wr_ptr`, `rd_ptr` (`$clog2(DEPTH)` bits each, wrapping naturally) and `count` (`$clog2(DEPTH)+1` bits).
- **Push:**
  - Condition: `i_c_vld && (count < DEPTH || pop)`.
  - A push while full is accepted only when a pop happens in the same cycle.
  - On push: write row and `in_idx` at `wr_ptr`, then `wr_ptr++`.
- **Drop:**
  - Condition: `i_c_vld` while full and no pop.
  - The row is discarded and `o_ovf` is set.
- **`in_idx`:**
  - Advances on every `i_c_vld`, whether the row is pushed or dropped, so tile alignment is preserved.
  - Wraps from `SIZE-1` to 0.
- **Pop:**
  - Condition: `o_vld && i_rdy`.
  - On pop: `rd_ptr++`.
  - If the popped entry is the last row of its tile, `o_tiles++`.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Outputs:
  - `o_vld = (count != 0)`.
  - `o_row` and `o_row_idx` come from the entry at `rd_ptr`.
  - `o_last = (o_row_idx == SIZE-1)`.
  - `o_row`, `o_row_idx` and `o_last` are forced to 0 whenever `o_vld = 0`.
- `o_tile_room = (DEPTH - count) >= SIZE`, combinational from `count`.
- `o_ovf`: `i_clr_ovf` clears it; if a drop occurs in the same cycle, set wins.
- No arithmetic is done on row data; it passes through bit-exact.

## Timing
- Reset values: `o_vld=0`, `o_row=0`, `o_row_idx=0`, `o_last=0`, `o_ovf=0`, `o_tiles=0`, `o_tile_room=1`. Internally, pointers, `count` and `in_idx` are 0. Memory contents are not reset.
- Latency: a row pushed at edge N is visible with `o_vld=1` after edge N. There is no same-cycle bypass; when empty, `o_vld` stays 0 in the push cycle.
- Handshake:
  - `o_row` is stable while `o_vld && !i_rdy`.
  - `i_rdy` while `o_vld=0` has no effect.
- Full plus push plus pop in the same cycle: both take effect, `count` stays at `DEPTH`, no drop.
- Reset asserted mid-stream: on the next edge the FIFO is emptied, `in_idx` returns to 0, in-flight rows are lost and `o_ovf` is cleared. `i_c_vld` is ignored during reset.

## Structure
- Shared package `sa_pkg`:
  - default constants `SA_WIDTH=16`, `SA_SIZE=4`.
  - typedef of the FIFO entry struct (row + index).
  - `sa_top` and this block use the same package defaults.
- Sub-module `sa_row_fifo`: a generic synchronous FIFO (data, push/pop, full/empty, count) with no drop logic.
- `sa_c_drain` wraps `sa_row_fifo` and adds `in_idx`, drop/overflow handling, output gating, the tile counter and the room credit.

## Test plan
All scenarios use `WIDTH=16`, `SIZE=4`, `DEPTH=8`.
1. **Reset:** hold `i_rst_n=0` for 3 cycles with `i_c_vld=1` → all outputs at reset values, `o_tile_room=1`, no push.
2. **Single tile, `i_rdy=1`:** push rows 0x0001..0x0004 (replicated per element) on 4 consecutive cycles → rows out in order, one cycle after each push. `o_row_idx` is 0,1,2,3; `o_last=1` on the 4th only; `o_tiles=1`.
3. **Backpressure:**
   - With `i_rdy=0`, push 8 rows → `o_tile_room` falls to 0 after the 5th push.
   - 9th row is dropped: `o_ovf=1`, `count=8`.
   - Then `i_rdy=1` → the first 8 rows drain intact with `o_row_idx` 0..3, 0..3, then `o_vld=0`.
4. **Full simultaneous push/pop:** when full, hold `i_c_vld=1` and `i_rdy=1` for 4 cycles → no drop, `count` stays 8, data order preserved.
5. **Overflow clear:** with `o_ovf=1`, assert `i_clr_ovf` alone → 0. Assert `i_clr_ovf` in the same cycle as a drop → `o_ovf` stays 1.
6. **Reset mid-stream:** reset after 3 rows pushed, then push 4 rows → output `o_row_idx` is 0..3 with `o_last` on the 4th; no stale rows appear.
